axiline_sgd_engine: RTL
=======================

Name: axiline_sgd_engine

Overview:
- Time-multiplexed SGD training engine for linear regression.
- Holds the model weight bank internally and streams a feature vector of LANES*CHUNKS elements in CHUNKS beats.
- Accumulates the dot product across beats, forms the error once, then writes back updated weights chunk-by-chunk and streams them out.
- Successor to the single-shot ip/comb/sgd datapath: supports vectors wider than the lane count and adds a start/done + valid/ready control FSM.

Parameters:
- BITWIDTH, 8, signed two's-complement element width.
- LANES, 18, multipliers per beat (elements per chunk).
- CHUNKS, 4, beats per feature vector; vector length = LANES*CHUNKS; must be >= 1.
- FRAC, 4, fractional bits of the fixed-point format.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  begin operation; sampled only in IDLE
- load_w  in  1  sampled with start; 1 = weight load, 0 = train step
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts a beat this cycle
- in_x  in  BITWIDTH*LANES  feature chunk (train)
- in_w  in  BITWIDTH*LANES  weight chunk (load)
- y  in  BITWIDTH  label; captured at start
- bias  in  BITWIDTH  bias; captured at start
- mu  in  BITWIDTH  learning rate (Q FRAC); captured at start
- busy  out  1  high whenever state != IDLE
- out_valid  out  1  updated weight chunk valid (1-cycle pulse per chunk)
- out_chunk  out  clog2(CHUNKS) (min 1)  index of out_data chunk
- out_data  out  BITWIDTH*LANES  updated weight chunk
- done  out  1  1-cycle pulse at end of load or train

Behaviour:
- Reset (rst==0 at posedge): state IDLE. All outputs 0. Weight bank, x buffer, accumulator, err, and captured y/bias/mu cleared to 0. Applies mid-operation: any in-flight operation is aborted with no done.
- States: IDLE, LOAD, DOT, GRAD, UPDATE.
- IDLE: in_ready=0. start=1 captures y/bias/mu, clears the accumulator and the beat counter c, then goes to LOAD if load_w=1, else to DOT. start while busy is ignored.
- LOAD: in_ready=1. Each accepted beat (in_valid && in_ready) writes bank[c]<=in_w and increments c. After the CHUNKS-th beat: next state IDLE, done=1 for the following cycle.
- DOT: in_ready=1. Each accepted beat stores x_buf[c]<=in_x and acc += sum over lanes of x*w(bank[c]). Products are full 2*BITWIDTH signed; the accumulator is 2*BITWIDTH+clog2(LANES*CHUNKS) bits, so it never overflows. After the CHUNKS-th beat: next state GRAD. in_valid low stalls indefinitely with no timeout.
- GRAD (1 cycle): dot = acc>>>FRAC, truncated (wrap) to BITWIDTH. err <= dot + bias - y, BITWIDTH wrap. c <= 0.
- UPDATE (CHUNKS cycles, no backpressure), per lane:
  - d = ((mu*err)>>>FRAC) truncated to BITWIDTH.
  - delta = ((d*x)>>>FRAC) truncated.
  - w_new = w - delta, wrap.
  - At the clock edge: bank[c]<=w_new, out_data<=w_new, out_chunk<=c, out_valid<=1.
- Output timing: out_valid is high the cycle after each UPDATE cycle, so the first out_valid comes 2 cycles after the last DOT accept. done is asserted together with the last out_valid; the state is already IDLE in that cycle.
- start coincident with done is accepted, allowing back-to-back operations.
- Arithmetic shifts are signed (floor toward -inf).
- in_x is ignored in LOAD; in_w is ignored in DOT.

Optional Feature:
- Macro AXL_SGD_SAT_EN.
- Defined: the dot truncation, err, d, delta and w_new saturate to [-(2^(BITWIDTH-1)), 2^(BITWIDTH-1)-1] instead of wrapping.
- Undefined: all these narrowings wrap (two's-complement truncation). No port changes either way.

Test Plan:
- Config BITWIDTH=8, LANES=2, CHUNKS=2, FRAC=0. Load all weights 1, then train with x all 2, bias 0, y 4, mu 1 -> dot=8, err=4, out_data chunk0 and chunk1 each lanes 0xF9 (-7); done coincident with the chunk1 out_valid.
- Same config, in_valid held low 5 cycles mid-DOT -> in_ready stays 1, no out_valid, result identical to the first scenario.
- Reset asserted during UPDATE after chunk0 -> all outputs 0 the next cycle, no done; a following load/train sequence behaves as in the first scenario.
- start pulsed while busy -> ignored. start coincident with done -> second operation begins; its first DOT beat is accepted the next cycle.
- Weights 127, x 127, y 0, bias 0, mu 1, FRAC=0:
  - without AXL_SGD_SAT_EN: wrapped values bit-exact to the reference model.
  - with AXL_SGD_SAT_EN: err=127, w_new=0.
- Default params (18x4, FRAC=4), 200 random vectors -> bit-exact against the fixed-point reference model.

Source files
------------

// File: rtl/axiline_sgd_engine.sv
// axiline_sgd_engine: time-multiplexed SGD engine for linear regression.
// Holds a LANES*CHUNKS weight bank and accumulates a streamed dot product.
// It forms the error once, then updates and streams the weights per chunk.
// Ports: clk, rst (sync, active-low), start/load_w (sampled in IDLE),
//        in_valid/in_ready with in_x (train) or in_w (load),
//        y/bias/mu (captured at start), busy, out_valid/out_chunk/out_data,
//        done.
// Optional: define AXL_SGD_SAT_EN to saturate every narrowing instead of
//           wrapping it.
module axiline_sgd_engine #(
    parameter int BITWIDTH = 8,
    parameter int LANES    = 18,
    parameter int CHUNKS   = 4,
    parameter int FRAC     = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic                                       load_w,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [BITWIDTH*LANES-1:0]                  in_x,
    input  logic [BITWIDTH*LANES-1:0]                  in_w,
    input  logic [BITWIDTH-1:0]                        y,
    input  logic [BITWIDTH-1:0]                        bias,
    input  logic [BITWIDTH-1:0]                        mu,
    output logic                                       busy,
    output logic                                       out_valid,
    output logic [(CHUNKS>1?$clog2(CHUNKS):1)-1:0]     out_chunk,
    output logic [BITWIDTH*LANES-1:0]                  out_data,
    output logic                                       done
);

    localparam int CW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int NE   = LANES * CHUNKS;
    localparam int ACCW = 2 * BITWIDTH + $clog2(NE);
    localparam int W    = BITWIDTH * LANES;

    localparam logic signed [ACCW-1:0] SMAX = ACCW'(2 ** (BITWIDTH - 1) - 1);
    localparam logic signed [ACCW-1:0] SMIN = ~SMAX;

    typedef enum logic [2:0] {IDLE, LOAD, DOT, GRAD, UPDATE} state_t;

    state_t                     state_q;
    logic [CW-1:0]              c_q;
    logic [W-1:0]               bank_q [CHUNKS];
    logic [W-1:0]               x_q    [CHUNKS];
    logic signed [ACCW-1:0]     acc_q;
    logic signed [BITWIDTH-1:0] err_q;
    logic signed [BITWIDTH-1:0] y_q;
    logic signed [BITWIDTH-1:0] bias_q;
    logic signed [BITWIDTH-1:0] mu_q;
    logic                       out_valid_q;
    logic                       done_q;
    logic [CW-1:0]              out_chunk_q;
    logic [W-1:0]               out_data_q;

    // Narrow a wide signed value to BITWIDTH, by wrap or by clamp.
    function automatic logic signed [BITWIDTH-1:0] narrow(
        input logic signed [ACCW-1:0] v
    );
`ifdef AXL_SGD_SAT_EN
        if (v > SMAX) return SMAX[BITWIDTH-1:0];
        if (v < SMIN) return SMIN[BITWIDTH-1:0];
        return v[BITWIDTH-1:0];
`else
        return v[BITWIDTH-1:0];
`endif
    endfunction

    logic                       accept;
    logic                       last;
    logic signed [2*BITWIDTH-1:0] prod;
    logic signed [2*BITWIDTH-1:0] md;
    logic signed [2*BITWIDTH-1:0] dx;
    logic signed [ACCW-1:0]     acc_d;
    logic signed [BITWIDTH-1:0] dot;
    logic signed [BITWIDTH-1:0] err_d;
    logic signed [BITWIDTH-1:0] d;
    logic signed [BITWIDTH-1:0] dl;
    logic signed [BITWIDTH-1:0] wl;
    logic [W-1:0]               w_new;

    assign in_ready = (state_q == LOAD) || (state_q == DOT);
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid && in_ready;
    assign last     = (c_q == CW'(CHUNKS - 1));

    // Partial dot product of the current beat against its weight chunk.
    always_comb begin
        acc_d = acc_q;
        prod  = '0;
        for (int l = 0; l < LANES; l++) begin
            prod  = $signed(in_x[l*BITWIDTH +: BITWIDTH])
                  * $signed(bank_q[c_q][l*BITWIDTH +: BITWIDTH]);
            acc_d = acc_d + ACCW'(prod);
        end
    end

    assign dot   = narrow(acc_q >>> FRAC);
    assign err_d = narrow(ACCW'(dot) + ACCW'(bias_q) - ACCW'(y_q));
    assign md    = mu_q * err_q;
    assign d     = narrow(ACCW'(md >>> FRAC));

    // Per-lane weight update for the chunk selected by c_q.
    always_comb begin
        w_new = '0;
        dx    = '0;
        dl    = '0;
        wl    = '0;
        for (int l = 0; l < LANES; l++) begin
            wl = $signed(bank_q[c_q][l*BITWIDTH +: BITWIDTH]);
            dx = d * $signed(x_q[c_q][l*BITWIDTH +: BITWIDTH]);
            dl = narrow(ACCW'(dx >>> FRAC));
            w_new[l*BITWIDTH +: BITWIDTH] = narrow(ACCW'(wl) - ACCW'(dl));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            c_q         <= '0;
            acc_q       <= '0;
            err_q       <= '0;
            y_q         <= '0;
            bias_q      <= '0;
            mu_q        <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            out_chunk_q <= '0;
            out_data_q  <= '0;
            for (int k = 0; k < CHUNKS; k++) begin
                bank_q[k] <= '0;
                x_q[k]    <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        y_q     <= y;
                        bias_q  <= bias;
                        mu_q    <= mu;
                        acc_q   <= '0;
                        c_q     <= '0;
                        state_q <= load_w ? LOAD : DOT;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        bank_q[c_q] <= in_w;
                        c_q         <= c_q + 1'b1;
                        if (last) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DOT: begin
                    if (accept) begin
                        x_q[c_q] <= in_x;
                        acc_q    <= acc_d;
                        c_q      <= c_q + 1'b1;
                        if (last) state_q <= GRAD;
                    end
                end
                GRAD: begin
                    err_q   <= err_d;
                    c_q     <= '0;
                    state_q <= UPDATE;
                end
                UPDATE: begin
                    bank_q[c_q] <= w_new;
                    out_data_q  <= w_new;
                    out_chunk_q <= c_q;
                    out_valid_q <= 1'b1;
                    c_q         <= c_q + 1'b1;
                    if (last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_chunk = out_chunk_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

endmodule
